// File: rtl/aclk_time_counter.sv
// 24-hour BCD time-of-day counter (HH:MM) driven by timebase strobes.
// Optional seconds digits are enabled with `define ACLK_SECONDS_EN.
module aclk_time_counter #(
    parameter logic [15:0] RESET_TIME = 16'h0000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       one_second,
    input  logic       load_new_c,
    input  logic [3:0] new_time_ms_hr,
    input  logic [3:0] new_time_ls_hr,
    input  logic [3:0] new_time_ms_min,
    input  logic [3:0] new_time_ls_min,
`ifdef ACLK_SECONDS_EN
    input  logic [3:0] new_time_ms_sec,
    input  logic [3:0] new_time_ls_sec,
    output logic [3:0] current_time_ms_sec,
    output logic [3:0] current_time_ls_sec,
`endif
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       reset_count,
    output logic       load_err,
    output logic       day_wrap
);

    logic       load_ok;
    logic       min_tick;
    logic       hr_wrap;
    logic [3:0] nxt_ms_hr;
    logic [3:0] nxt_ls_hr;
    logic [3:0] nxt_ms_min;
    logic [3:0] nxt_ls_min;

`ifdef ACLK_SECONDS_EN
    logic sec_wrap;
    logic unused_minute;

    assign unused_minute = one_minute;
    assign sec_wrap      = (current_time_ms_sec == 4'd5) &&
                           (current_time_ls_sec == 4'd9);
    assign min_tick      = one_second && sec_wrap;
`else
    logic unused_second;

    assign unused_second = one_second;
    assign min_tick      = one_minute;
`endif

    always_comb begin
        load_ok = 1'b1;
        if (new_time_ms_hr > 4'd2)
            load_ok = 1'b0;
        if (new_time_ls_hr > 4'd9)
            load_ok = 1'b0;
        if (new_time_ms_hr == 4'd2 && new_time_ls_hr > 4'd3)
            load_ok = 1'b0;
        if (new_time_ms_min > 4'd5)
            load_ok = 1'b0;
        if (new_time_ls_min > 4'd9)
            load_ok = 1'b0;
`ifdef ACLK_SECONDS_EN
        if (new_time_ms_sec > 4'd5)
            load_ok = 1'b0;
        if (new_time_ls_sec > 4'd9)
            load_ok = 1'b0;
`endif
    end

    // Next HH:MM one minute on, with the midnight rollover flagged.
    always_comb begin
        nxt_ms_hr  = current_time_ms_hr;
        nxt_ls_hr  = current_time_ls_hr;
        nxt_ms_min = current_time_ms_min;
        nxt_ls_min = current_time_ls_min;
        hr_wrap    = 1'b0;
        if (current_time_ls_min != 4'd9) begin
            nxt_ls_min = current_time_ls_min + 4'd1;
        end else begin
            nxt_ls_min = 4'd0;
            if (current_time_ms_min != 4'd5) begin
                nxt_ms_min = current_time_ms_min + 4'd1;
            end else begin
                nxt_ms_min = 4'd0;
                if (current_time_ms_hr == 4'd2 &&
                    current_time_ls_hr == 4'd3) begin
                    nxt_ms_hr = 4'd0;
                    nxt_ls_hr = 4'd0;
                    hr_wrap   = 1'b1;
                end else if (current_time_ls_hr == 4'd9) begin
                    nxt_ls_hr = 4'd0;
                    nxt_ms_hr = current_time_ms_hr + 4'd1;
                end else begin
                    nxt_ls_hr = current_time_ls_hr + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            current_time_ms_hr  <= RESET_TIME[15:12];
            current_time_ls_hr  <= RESET_TIME[11:8];
            current_time_ms_min <= RESET_TIME[7:4];
            current_time_ls_min <= RESET_TIME[3:0];
`ifdef ACLK_SECONDS_EN
            current_time_ms_sec <= 4'd0;
            current_time_ls_sec <= 4'd0;
`endif
            reset_count         <= 1'b0;
            load_err            <= 1'b0;
            day_wrap            <= 1'b0;
        end else begin
            reset_count <= 1'b0;
            load_err    <= 1'b0;
            day_wrap    <= 1'b0;
            if (load_new_c) begin
                if (load_ok) begin
                    current_time_ms_hr  <= new_time_ms_hr;
                    current_time_ls_hr  <= new_time_ls_hr;
                    current_time_ms_min <= new_time_ms_min;
                    current_time_ls_min <= new_time_ls_min;
`ifdef ACLK_SECONDS_EN
                    current_time_ms_sec <= new_time_ms_sec;
                    current_time_ls_sec <= new_time_ls_sec;
`endif
                    reset_count         <= 1'b1;
                end else begin
                    load_err <= 1'b1;
                end
            end else begin
`ifdef ACLK_SECONDS_EN
                if (one_second) begin
                    if (current_time_ls_sec != 4'd9) begin
                        current_time_ls_sec <= current_time_ls_sec + 4'd1;
                    end else begin
                        current_time_ls_sec <= 4'd0;
                        if (sec_wrap)
                            current_time_ms_sec <= 4'd0;
                        else
                            current_time_ms_sec <= current_time_ms_sec + 4'd1;
                    end
                end
`endif
                if (min_tick) begin
                    current_time_ms_hr  <= nxt_ms_hr;
                    current_time_ls_hr  <= nxt_ls_hr;
                    current_time_ms_min <= nxt_ms_min;
                    current_time_ls_min <= nxt_ls_min;
                    day_wrap            <= hr_wrap;
                end
            end
        end
    end

endmodule

// File: tb/tb_aclk_time_counter.sv
// Directed self-checking bench for aclk_time_counter.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_aclk_time_counter;

    logic       clock;
    logic       reset;
    logic       one_minute;
    logic       one_second;
    logic       load_new_c;
    logic [3:0] new_time_ms_hr;
    logic [3:0] new_time_ls_hr;
    logic [3:0] new_time_ms_min;
    logic [3:0] new_time_ls_min;
    logic [3:0] current_time_ms_hr;
    logic [3:0] current_time_ls_hr;
    logic [3:0] current_time_ms_min;
    logic [3:0] current_time_ls_min;
    logic       reset_count;
    logic       load_err;
    logic       day_wrap;
`ifdef ACLK_SECONDS_EN
    logic [3:0] new_time_ms_sec;
    logic [3:0] new_time_ls_sec;
    logic [3:0] current_time_ms_sec;
    logic [3:0] current_time_ls_sec;
`endif

    int n_cmp;
    int n_fail;

    aclk_time_counter dut (
        .clock               (clock),
        .reset               (reset),
        .one_minute          (one_minute),
        .one_second          (one_second),
        .load_new_c          (load_new_c),
        .new_time_ms_hr      (new_time_ms_hr),
        .new_time_ls_hr      (new_time_ls_hr),
        .new_time_ms_min     (new_time_ms_min),
        .new_time_ls_min     (new_time_ls_min),
`ifdef ACLK_SECONDS_EN
        .new_time_ms_sec     (new_time_ms_sec),
        .new_time_ls_sec     (new_time_ls_sec),
        .current_time_ms_sec (current_time_ms_sec),
        .current_time_ls_sec (current_time_ls_sec),
`endif
        .current_time_ms_hr  (current_time_ms_hr),
        .current_time_ls_hr  (current_time_ls_hr),
        .current_time_ms_min (current_time_ms_min),
        .current_time_ls_min (current_time_ls_min),
        .reset_count         (reset_count),
        .load_err            (load_err),
        .day_wrap            (day_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] cur();
        return {current_time_ms_hr, current_time_ls_hr,
                current_time_ms_min, current_time_ls_min};
    endfunction

    function automatic logic [2:0] pulses();
        return {reset_count, load_err, day_wrap};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_new(input logic [15:0] t);
        new_time_ms_hr  = t[15:12];
        new_time_ls_hr  = t[11:8];
        new_time_ms_min = t[7:4];
        new_time_ls_min = t[3:0];
    endtask

    task automatic load_one(input logic [15:0] t);
        set_new(t);
        load_new_c = 1'b1;
        step();
        load_new_c = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if (cur() !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_time: got %h want 0000", cur());
        end
        n_cmp++;
        if (pulses() !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 000", pulses());
        end
        reset = 1'b1;
        load_one(16'h1234);
        one_minute = 1'b1;
        step();
        one_minute = 1'b0;
        n_cmp++;
        if (cur() !== 16'h1235) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %h want 1235", cur());
        end
        load_one(16'h1234);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (cur() !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset_time: got %h want 0000", cur());
        end
        n_cmp++;
        if (pulses() !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset_pulses: got %b want 000", pulses());
        end
        one_minute = 1'b1;
        step();
        n_cmp++;
        if (cur() !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_overrides_strobe: got %h want 0000", cur());
        end
        reset = 1'b1;
        step();
        one_minute = 1'b0;
        n_cmp++;
        if (cur() !== 16'h0001) begin
            n_fail++;
            $display("FAIL resume_after_reset: got %h want 0001", cur());
        end
    endtask

    task automatic test_load();
        load_one(16'h1234);
        n_cmp++;
        if (cur() !== 16'h1234) begin
            n_fail++;
            $display("FAIL load_time: got %h want 1234", cur());
        end
        n_cmp++;
        if (pulses() !== 3'b100) begin
            n_fail++;
            $display("FAIL load_pulses: got %b want 100", pulses());
        end
        step();
        n_cmp++;
        if (reset_count !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_count_width: got %b want 0", reset_count);
        end
        one_minute = 1'b1;
        step();
        one_minute = 1'b0;
        n_cmp++;
        if (cur() !== 16'h1235) begin
            n_fail++;
            $display("FAIL load_then_minute: got %h want 1235", cur());
        end
    endtask

    task automatic test_carry();
        logic [15:0] start_t [5] = '{16'h0959, 16'h1959, 16'h2359,
                                     16'h1259, 16'h0009};
        logic [15:0] exp_t   [5] = '{16'h1000, 16'h2000, 16'h0000,
                                     16'h1300, 16'h0010};
        logic        exp_w   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            load_one(start_t[i]);
            one_minute = 1'b1;
            step();
            one_minute = 1'b0;
            n_cmp++;
            if (cur() !== exp_t[i]) begin
                n_fail++;
                $display("FAIL carry_%h: got %h want %h",
                         start_t[i], cur(), exp_t[i]);
            end
            n_cmp++;
            if (day_wrap !== exp_w[i]) begin
                n_fail++;
                $display("FAIL day_wrap_%h: got %b want %b",
                         start_t[i], day_wrap, exp_w[i]);
            end
            step();
            n_cmp++;
            if (day_wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL day_wrap_width_%h: got %b want 0",
                         start_t[i], day_wrap);
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] bad [6] = '{16'h2400, 16'h2360, 16'h2A00,
                                 16'h3000, 16'h120A, 16'h0F00};
        load_one(16'h1500);
        for (int i = 0; i < 6; i++) begin
            load_one(bad[i]);
            n_cmp++;
            if (cur() !== 16'h1500) begin
                n_fail++;
                $display("FAIL illegal_time_%h: got %h want 1500",
                         bad[i], cur());
            end
            n_cmp++;
            if (pulses() !== 3'b010) begin
                n_fail++;
                $display("FAIL illegal_pulses_%h: got %b want 010",
                         bad[i], pulses());
            end
            step();
            n_cmp++;
            if (load_err !== 1'b0) begin
                n_fail++;
                $display("FAIL load_err_width_%h: got %b want 0",
                         bad[i], load_err);
            end
        end
    endtask

    task automatic test_coincident();
        one_minute = 1'b1;
        load_one(16'h0800);
        one_minute = 1'b0;
        n_cmp++;
        if (cur() !== 16'h0800) begin
            n_fail++;
            $display("FAIL load_vs_minute: got %h want 0800", cur());
        end
        n_cmp++;
        if (reset_count !== 1'b1) begin
            n_fail++;
            $display("FAIL load_vs_minute_rc: got %b want 1", reset_count);
        end
        one_minute = 1'b1;
        step();
        one_minute = 1'b0;
        n_cmp++;
        if (cur() !== 16'h0801) begin
            n_fail++;
            $display("FAIL minute_after_coincident: got %h want 0801", cur());
        end
        one_minute = 1'b1;
        load_one(16'h2400);
        one_minute = 1'b0;
        n_cmp++;
        if ({cur(), pulses()} !== {16'h0801, 3'b010}) begin
            n_fail++;
            $display("FAIL illegal_vs_minute: got %h/%b want 0801/010",
                     cur(), pulses());
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [6] = '{16'h0100, 16'h2400, 16'h0230,
                                  16'h1111, 16'h1111, 16'h1111};
        logic [15:0] exp_t [6] = '{16'h0100, 16'h0100, 16'h0230,
                                   16'h1111, 16'h1111, 16'h1111};
        logic [2:0]  exp_p [6] = '{3'b100, 3'b010, 3'b100,
                                   3'b100, 3'b100, 3'b100};
        load_new_c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_new(vals[i]);
            step();
            n_cmp++;
            if ({cur(), pulses()} !== {exp_t[i], exp_p[i]}) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: got %h/%b want %h/%b",
                         i, cur(), pulses(), exp_t[i], exp_p[i]);
            end
        end
        load_new_c = 1'b0;
        step();
        n_cmp++;
        if (pulses() !== 3'b000) begin
            n_fail++;
            $display("FAIL back_to_back_end: got %b want 000", pulses());
        end
    endtask

    task automatic test_held_strobe();
        logic [15:0] exp_t [3] = '{16'h1112, 16'h1113, 16'h1114};
        one_minute = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (cur() !== exp_t[i]) begin
                n_fail++;
                $display("FAIL held_minute_%0d: got %h want %h",
                         i, cur(), exp_t[i]);
            end
        end
        one_minute = 1'b0;
        step();
        n_cmp++;
        if (cur() !== 16'h1114) begin
            n_fail++;
            $display("FAIL held_release: got %h want 1114", cur());
        end
    endtask

`ifdef ACLK_SECONDS_EN
    task automatic test_seconds();
        new_time_ms_sec = 4'd5;
        new_time_ls_sec = 4'd8;
        load_one(16'h2359);
        new_time_ms_sec = 4'd0;
        new_time_ls_sec = 4'd0;
        one_minute = 1'b1;
        step();
        one_minute = 1'b0;
        n_cmp++;
        if ({cur(), current_time_ms_sec, current_time_ls_sec} !== 24'h235958) begin
            n_fail++;
            $display("FAIL minute_ignored: got %h%h%h want 235958",
                     cur(), current_time_ms_sec, current_time_ls_sec);
        end
        one_second = 1'b1;
        step();
        n_cmp++;
        if ({cur(), current_time_ms_sec, current_time_ls_sec} !== 24'h235959) begin
            n_fail++;
            $display("FAIL second_step: got %h%h%h want 235959",
                     cur(), current_time_ms_sec, current_time_ls_sec);
        end
        step();
        one_second = 1'b0;
        n_cmp++;
        if ({cur(), current_time_ms_sec, current_time_ls_sec, day_wrap}
            !== {24'h000000, 1'b1}) begin
            n_fail++;
            $display("FAIL second_day_wrap: got %h%h%h/%b want 000000/1",
                     cur(), current_time_ms_sec, current_time_ls_sec, day_wrap);
        end
    endtask
`else
    task automatic test_seconds();
        one_second = 1'b1;
        step();
        step();
        one_second = 1'b0;
        n_cmp++;
        if ({cur(), pulses()} !== {16'h1114, 3'b000}) begin
            n_fail++;
            $display("FAIL second_ignored: got %h/%b want 1114/000",
                     cur(), pulses());
        end
    endtask
`endif

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b0;
        one_minute = 1'b0;
        one_second = 1'b0;
        load_new_c = 1'b0;
        set_new(16'h0000);
`ifdef ACLK_SECONDS_EN
        new_time_ms_sec = 4'd0;
        new_time_ls_sec = 4'd0;
`endif
        test_reset();
        test_load();
        test_carry();
        test_illegal();
        test_coincident();
        test_back_to_back();
`ifndef ACLK_SECONDS_EN
        test_held_strobe();
`endif
        test_seconds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
